alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath's combinational ALU.
- Adds a Run/Done handshake, registered result and status flags, and iterative multi-cycle multiply and barrel-free shifts.
- Sits between the register file/immediate path and the bus; the control unit starts an operation with Run and waits for Done.
- Single-cycle ops keep the existing opcode map.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4, power of two).
- SHW, log2(WIDTH), width of the shift-amount field taken from Ry.

Ports:
- Clock    in   1      rising-edge clock.
- Resetn   in   1      synchronous, active-low reset.
- Run      in   1      start request; sampled only in IDLE.
- OpSelect in   3      operation code.
- A        in   WIDTH  operand A.
- Ry       in   WIDTH  operand B / shift amount (low SHW bits).
- Imm      in   WIDTH  immediate for ldi.
- result   out  WIDTH  registered result.
- Done     out  1      one-cycle pulse: result/flags valid for the completed op.
- Busy     out  1      high while a multi-cycle op iterates.
- flags    out  4      {Z,N,C,V}, registered with result.

Behaviour:
- Reset (Resetn=0 at a rising edge): state=IDLE, result=0, flags=0, Done=0, Busy=0, counter=0.
  - Reset mid-operation aborts the op; no Done is produced.
- Opcodes:
  - 000 add: A+Ry.
  - 001 sub: A-Ry.
  - 010 nand: ~(A&Ry).
  - 011 mul: unsigned A*Ry, low WIDTH bits.
  - 100 out: A.
  - 101 ldi: Imm.
  - 110 shl: A<<Ry[SHW-1:0].
  - 111 shr: A>>Ry[SHW-1:0], logical.
- Accept: at edge k with state=IDLE and Run=1.
  - Operands and opcode are latched at edge k.
  - Inputs may change afterwards with no effect.
- Single-cycle ops (000,001,010,100,101), and shl/shr with amount 0:
  - result/flags written at edge k.
  - Done=1 for the cycle after edge k.
  - State stays IDLE.
- mul:
  - State goes to EXEC at edge k; Busy=1 from edge k.
  - Shift-add, one multiplier bit per edge, LSB first.
  - result/flags written at edge k+WIDTH; Busy drops and Done=1 in the cycle after that edge.
  - Latency is WIDTH+1 edges to Done sampled.
- shl/shr with amount n>0:
  - One bit per edge; result written at edge k+n.
  - Done in the following cycle.
- States: IDLE -> EXEC (mul, or shift with n>0) -> IDLE on the final iteration.
  - Single-cycle ops never leave IDLE.
- Run while Busy=1 is ignored (not queued).
- Run=1 in the Done cycle is accepted (state is IDLE), giving back-to-back ops.
- Between operations, result and flags hold their values. Done is 0 except for its single pulse.
- Arithmetic: modulo 2^WIDTH.
- Flags:
  - Z=(result==0).
  - N=result MSB.
  - add: C=carry-out; V=signed overflow.
  - sub: C=1 when A>=Ry unsigned (no borrow); V=signed overflow.
  - mul: C=1 if the high WIDTH bits of the full product are nonzero; V=0.
  - shl/shr: C=last bit shifted out (0 if n=0); V=0.
  - nand/out/ldi: C=V=0.
- Unused shift bits: only Ry[SHW-1:0] counts; upper Ry bits are ignored.

Test Plan:
- Reset, then add A=0x7FFF, Ry=0x0001 -> Done at cycle k+1, result=0x8000, flags Z0 N1 C0 V1.
- sub A=0x0003, Ry=0x0005 -> result=0xFFFE, C=0, N=1; sub A=5, Ry=5 -> result=0, Z=1, C=1.
- mul A=0x0100, Ry=0x0101 -> Busy for 16 cycles, Done at edge k+17, result=0x0100, C=1. Run pulses during Busy are ignored.
- shl A=0x8001, Ry=0xFFF1 (n=1) -> result=0x0002, C=1, Done at k+2; shr n=0 -> result=A, Done at k+1.
- ldi Imm=0xBEEF in the Done cycle of a preceding nand -> accepted back-to-back, result=0xBEEF, N=1.
- Resetn=0 during the mul at cycle k+5 -> result=0, flags=0, Busy=0, no Done; the next add completes normally.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq : registered ALU with Run/Done handshake, iterative mul and shifts   |
// | Rev 1.0 : initial release                                                    |
// +----------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [2:0]       OpSelect,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Ry,
  input  logic [WIDTH-1:0] Imm,
  output logic [WIDTH-1:0] result,
  output logic             Done,
  output logic             Busy,
  output logic [3:0]       flags
);

  typedef enum logic [0:0] {IDLE = 1'b0, EXEC = 1'b1} state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_OUT  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;
  localparam int         MSB     = WIDTH - 1;

  state_t               state_q,  state_d;
  logic [2:0]           op_q,     op_d;
  logic [SHW:0]         cnt_q,    cnt_d;
  logic [WIDTH-1:0]     sh_q,     sh_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q,   prod_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           flags_q,  flags_d;
  logic                 done_q,   done_d;
  logic                 busy_q,   busy_d;

  logic [WIDTH:0]       add_w, sub_w;
  logic                 add_v, sub_v;
  logic [2*WIDTH-1:0]   prod_next;
  logic [WIDTH-1:0]     sh_next;
  logic                 sh_out;
  logic [SHW-1:0]       shamt;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {r == '0, r[MSB], c, v};
  endfunction

  assign add_w     = {1'b0, A} + {1'b0, Ry};
  assign sub_w     = {1'b0, A} - {1'b0, Ry};
  assign add_v     = (A[MSB] == Ry[MSB]) && (add_w[MSB] != A[MSB]);
  assign sub_v     = (A[MSB] != Ry[MSB]) && (sub_w[MSB] != A[MSB]);
  assign shamt     = Ry[SHW-1:0];
  assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign sh_next   = (op_q == OP_SHL) ? (sh_q << 1) : (sh_q >> 1);
  // The bit leaving on this step; on the final step it becomes the carry flag.
  assign sh_out    = (op_q == OP_SHL) ? sh_q[MSB] : sh_q[0];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (Run) begin
          op_d = OpSelect;
          case (OpSelect)
            OP_ADD: begin
              result_d = add_w[WIDTH-1:0];
              flags_d  = mk_flags(add_w[WIDTH-1:0], add_w[WIDTH], add_v);
              done_d   = 1'b1;
            end
            OP_SUB: begin
              result_d = sub_w[WIDTH-1:0];
              flags_d  = mk_flags(sub_w[WIDTH-1:0], ~sub_w[WIDTH], sub_v);
              done_d   = 1'b1;
            end
            OP_NAND: begin
              result_d = ~(A & Ry);
              flags_d  = mk_flags(~(A & Ry), 1'b0, 1'b0);
              done_d   = 1'b1;
            end
            OP_MUL: begin
              mcand_d  = {{WIDTH{1'b0}}, A};
              mplier_d = Ry;
              prod_d   = '0;
              cnt_d    = (SHW+1)'(WIDTH);
              busy_d   = 1'b1;
              state_d  = EXEC;
            end
            OP_OUT: begin
              result_d = A;
              flags_d  = mk_flags(A, 1'b0, 1'b0);
              done_d   = 1'b1;
            end
            OP_LDI: begin
              result_d = Imm;
              flags_d  = mk_flags(Imm, 1'b0, 1'b0);
              done_d   = 1'b1;
            end
            default: begin
              if (shamt == '0) begin
                result_d = A;
                flags_d  = mk_flags(A, 1'b0, 1'b0);
                done_d   = 1'b1;
              end else begin
                sh_d    = A;
                cnt_d   = {1'b0, shamt};
                busy_d  = 1'b1;
                state_d = EXEC;
              end
            end
          endcase
        end
      end
      EXEC: begin
        cnt_d = cnt_q - (SHW+1)'(1);
        if (op_q == OP_MUL) begin
          prod_d   = prod_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else begin
          sh_d = sh_next;
        end
        if (cnt_q == (SHW+1)'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (op_q == OP_MUL) begin
            result_d = prod_next[WIDTH-1:0];
            flags_d  = mk_flags(prod_next[WIDTH-1:0], |prod_next[2*WIDTH-1:WIDTH], 1'b0);
          end else begin
            result_d = sh_next;
            flags_d  = mk_flags(sh_next, sh_out, 1'b0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      sh_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign Done   = done_q;
  assign Busy   = busy_q;

endmodule
`default_nettype wire
